// File: rtl/round_timer_ctrl.sv
// round_timer_ctrl: whack-a-mole round sequencer sitting downstream of sec_counter.
// The last-seconds warn output is only built when ROUND_WARN_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, counter held clear and stopped
// ARM   | counter held clear and running until the synced count reads 0
// PLAY  | round running, counter enabled
// PAUSE | counter stopped, time_left frozen
// OVER  | round finished, waiting for start to re-arm

module round_timer_ctrl #(
    parameter int ROUND_LEN = 30,
    parameter int WARN_SECS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause_btn,
    input  logic [5:0] sec_in,
    output logic       sec_enable,
    output logic       sec_clear,
    output logic [5:0] time_left,
    output logic       sec_tick,
    output logic       playing,
    output logic       game_over,
    output logic       round_done,
    output logic       warn
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_PLAY,
        ST_PAUSE,
        ST_OVER
    } state_t;

    localparam logic [5:0] ROUND_LEN_V = 6'(ROUND_LEN);

    if (ROUND_LEN < 1 || ROUND_LEN > 63) begin : g_bad_round_len
        $error("round_timer_ctrl: ROUND_LEN must be in 1..63");
    end
    if (WARN_SECS < 0 || WARN_SECS > 63) begin : g_bad_warn_secs
        $error("round_timer_ctrl: WARN_SECS must be in 0..63");
    end

    state_t     state;
    state_t     state_nxt;
    logic [5:0] s1;
    logic [5:0] s2;
    logic [5:0] s3;
    logic [5:0] sec_stable;
    logic [5:0] time_left_nxt;
    logic       round_end;

    // sec_in crosses from clk_1hz; only accept a value seen on two consecutive samples
    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= '0;
            s2         <= '0;
            s3         <= '0;
            sec_stable <= '0;
            sec_tick   <= 1'b0;
        end else begin
            s1       <= sec_in;
            s2       <= s1;
            s3       <= s2;
            sec_tick <= (s2 == s3) && (s2 != sec_stable);
            if (s2 == s3) begin
                sec_stable <= s2;
            end
        end
    end

    assign round_end = (sec_stable >= ROUND_LEN_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            time_left  <= ROUND_LEN_V;
            round_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            time_left  <= time_left_nxt;
            round_done <= (state_nxt == ST_OVER) && (state != ST_OVER);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (sec_stable == 6'd0) begin
                    state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (round_end) begin
                    state_nxt = ST_OVER;
                end else if (pause_btn) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (round_end) begin
                    state_nxt = ST_OVER;
                end else if (!pause_btn) begin
                    state_nxt = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (start) begin
                    state_nxt = ST_ARM;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Computed against the next state so time_left lines up with the state register
    always_comb begin
        time_left_nxt = ROUND_LEN_V;
        if (state_nxt == ST_IDLE || state_nxt == ST_ARM) begin
            time_left_nxt = ROUND_LEN_V;
        end else if (round_end) begin
            time_left_nxt = 6'd0;
        end else begin
            time_left_nxt = ROUND_LEN_V - sec_stable;
        end
    end

    always_comb begin
        sec_clear  = 1'b0;
        sec_enable = 1'b0;
        playing    = 1'b0;
        game_over  = 1'b0;
        case (state)
            ST_IDLE: sec_clear = 1'b1;
            ST_ARM: begin
                sec_clear  = 1'b1;
                sec_enable = 1'b1;
            end
            ST_PLAY: begin
                sec_enable = 1'b1;
                playing    = 1'b1;
            end
            ST_PAUSE: sec_enable = 1'b0;
            ST_OVER:  game_over  = 1'b1;
            default:  sec_clear  = 1'b1;
        endcase
    end

`ifdef ROUND_WARN_EN
    localparam logic [5:0] WARN_V = 6'(WARN_SECS);

    logic warn_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= (state_nxt == ST_PLAY || state_nxt == ST_PAUSE)
                      && (time_left_nxt != 6'd0) && (time_left_nxt <= WARN_V);
        end
    end

    assign warn = warn_q;
`else
    assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Self-checking bench for round_timer_ctrl: drives sec_in the way sec_counter would
// and compares outputs against a seconds-level model of the round.
module tb_round_timer_ctrl;

    localparam int ROUND_LEN = 30;
    localparam int WARN_SECS = 5;
`ifdef ROUND_WARN_EN
    localparam bit WARN_ON = 1'b1;
`else
    localparam bit WARN_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pause_btn = 1'b0;
    logic [5:0] sec_in = 6'd0;
    logic       sec_enable;
    logic       sec_clear;
    logic [5:0] time_left;
    logic       sec_tick;
    logic       playing;
    logic       game_over;
    logic       round_done;
    logic       warn;

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;
    int done_cnt = 0;

    round_timer_ctrl #(
        .ROUND_LEN(ROUND_LEN),
        .WARN_SECS(WARN_SECS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause_btn (pause_btn),
        .sec_in    (sec_in),
        .sec_enable(sec_enable),
        .sec_clear (sec_clear),
        .time_left (time_left),
        .sec_tick  (sec_tick),
        .playing   (playing),
        .game_over (game_over),
        .round_done(round_done),
        .warn      (warn)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: seconds remaining and warning from the round rules
    function automatic int exp_time_left(input int sec);
        return (sec >= ROUND_LEN) ? 0 : ROUND_LEN - sec;
    endfunction

    function automatic bit exp_warn(input int tl, input bit live);
        return WARN_ON && live && (tl > 0) && (tl <= WARN_SECS);
    endfunction

    // Advance n clocks, sampling on falling edges and counting pulses
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sec_tick === 1'b1) tick_cnt++;
            if (round_done === 1'b1) done_cnt++;
        end
    endtask

    task automatic enter_play(input string name);
        int n;
        n = 0;
        while (playing !== 1'b1 && n < 8) begin
            step(1);
            n++;
        end
        checks++;
        if (playing !== 1'b1) begin
            errors++;
            $display("FAIL %s_enter_play: playing=%b after %0d clk, required 1", name, playing, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sec_in = 6'd17;
        step(2);
        checks++;
        if (sec_clear !== 1'b1 || sec_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: clear=%b enable=%b, required 1/0", sec_clear, sec_enable);
        end
        checks++;
        if (time_left !== 6'(ROUND_LEN)) begin
            errors++;
            $display("FAIL reset_time_left: got %0d, required %0d", time_left, ROUND_LEN);
        end
        checks++;
        if (game_over !== 1'b0 || playing !== 1'b0 || round_done !== 1'b0 || warn !== 1'b0
            || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: over=%b play=%b done=%b warn=%b tick=%b, required all 0",
                     game_over, playing, round_done, warn, sec_tick);
        end
        rst = 1'b0;
    endtask

    task automatic test_arm();
        sec_in = 6'd9;
        step(10);
        checks++;
        if (sec_clear !== 1'b1 || playing !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: clear=%b playing=%b, required 1/0", sec_clear, playing);
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(6);
        checks++;
        if (sec_clear !== 1'b1 || sec_enable !== 1'b1 || playing !== 1'b0) begin
            errors++;
            $display("FAIL arm_hold: clear=%b enable=%b playing=%b, required 1/1/0",
                     sec_clear, sec_enable, playing);
        end
        sec_in = 6'd0;
        enter_play("arm");
        checks++;
        if (sec_clear !== 1'b0 || sec_enable !== 1'b1 || time_left !== 6'(ROUND_LEN)) begin
            errors++;
            $display("FAIL arm_play_outputs: clear=%b enable=%b time_left=%0d, required 0/1/%0d",
                     sec_clear, sec_enable, time_left, ROUND_LEN);
        end
    endtask

    task automatic test_countdown();
        int tl;
        done_cnt = 0;
        for (int s = 1; s <= ROUND_LEN; s++) begin
            tick_cnt = 0;
            sec_in = 6'(s);
            step(int'($urandom_range(8, 20)));
            tl = exp_time_left(s);
            checks++;
            if (tick_cnt != 1) begin
                errors++;
                $display("FAIL countdown_ticks sec=%0d: got %0d ticks, required 1", s, tick_cnt);
            end
            checks++;
            if (time_left !== 6'(tl)) begin
                errors++;
                $display("FAIL countdown_time_left sec=%0d: got %0d, required %0d", s, time_left, tl);
            end
            checks++;
            if (warn !== exp_warn(tl, s < ROUND_LEN)) begin
                errors++;
                $display("FAIL countdown_warn sec=%0d: got %b, required %b", s, warn,
                         exp_warn(tl, s < ROUND_LEN));
            end
            checks++;
            if (playing !== (s < ROUND_LEN) || game_over !== (s >= ROUND_LEN)) begin
                errors++;
                $display("FAIL countdown_state sec=%0d: playing=%b over=%b", s, playing, game_over);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL countdown_round_done: got %0d pulse cycles, required 1", done_cnt);
        end
        checks++;
        if (sec_enable !== 1'b0 || sec_clear !== 1'b0) begin
            errors++;
            $display("FAIL over_ctrl: enable=%b clear=%b, required 0/0", sec_enable, sec_clear);
        end
    endtask

    task automatic test_glitch();
        bit saw_glitch;
        saw_glitch = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        checks++;
        if (sec_clear !== 1'b1 || playing !== 1'b0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL rearm: clear=%b playing=%b over=%b, required 1/0/0",
                     sec_clear, playing, game_over);
        end
        sec_in = 6'd0;
        enter_play("glitch");
        tick_cnt = 0;
        sec_in = 6'd5;
        step(10);
        sec_in = 6'd7;
        step(1);
        sec_in = 6'd6;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (time_left === 6'(exp_time_left(7))) saw_glitch = 1'b1;
        end
        checks++;
        if (saw_glitch || tick_cnt != 2) begin
            errors++;
            $display("FAIL glitch_reject: saw_sec7=%b ticks=%0d, required 0/2", saw_glitch, tick_cnt);
        end
        checks++;
        if (time_left !== 6'(exp_time_left(6))) begin
            errors++;
            $display("FAIL glitch_time_left: got %0d, required %0d", time_left, exp_time_left(6));
        end
    endtask

    task automatic test_pause();
        int n;
        int tl;
        for (int s = 7; s <= 12; s++) begin
            sec_in = 6'(s);
            step(10);
        end
        pause_btn = 1'b1;
        step(3);
        checks++;
        if (sec_enable !== 1'b0 || playing !== 1'b0 || game_over !== 1'b0
            || time_left !== 6'(exp_time_left(12))) begin
            errors++;
            $display("FAIL pause_enter: enable=%b playing=%b over=%b time_left=%0d, required 0/0/0/%0d",
                     sec_enable, playing, game_over, time_left, exp_time_left(12));
        end
        step(int'($urandom_range(10, 30)));
        checks++;
        if (time_left !== 6'(exp_time_left(12))) begin
            errors++;
            $display("FAIL pause_frozen: got %0d, required %0d", time_left, exp_time_left(12));
        end
        pause_btn = 1'b0;
        step(3);
        checks++;
        if (playing !== 1'b1 || sec_enable !== 1'b1) begin
            errors++;
            $display("FAIL pause_release: playing=%b enable=%b, required 1/1", playing, sec_enable);
        end
        for (int s = 13; s < ROUND_LEN; s++) begin
            sec_in = 6'(s);
            step(int'($urandom_range(8, 14)));
            tl = exp_time_left(s);
            checks++;
            if (time_left !== 6'(tl) || warn !== exp_warn(tl, 1'b1)) begin
                errors++;
                $display("FAIL resume_count sec=%0d: time_left=%0d warn=%b, required %0d/%b",
                         s, time_left, warn, tl, exp_warn(tl, 1'b1));
            end
        end
        // Raise pause in the very cycle the final second becomes visible
        done_cnt = 0;
        sec_in = 6'(ROUND_LEN);
        n = 0;
        while (sec_tick !== 1'b1 && n < 10) begin
            step(1);
            n++;
        end
        pause_btn = 1'b1;
        step(1);
        checks++;
        if (game_over !== 1'b1 || playing !== 1'b0 || sec_enable !== 1'b0) begin
            errors++;
            $display("FAIL over_beats_pause: over=%b playing=%b enable=%b, required 1/0/0",
                     game_over, playing, sec_enable);
        end
        step(3);
        pause_btn = 1'b0;
        checks++;
        if (game_over !== 1'b1 || done_cnt != 1 || warn !== 1'b0) begin
            errors++;
            $display("FAIL over_hold: over=%b done_pulses=%0d warn=%b, required 1/1/0",
                     game_over, done_cnt, warn);
        end
    endtask

    task automatic test_back_to_back();
        int sec;
        bit paused;
        int iter;
        int tl;
        for (int r = 0; r < 2; r++) begin
            done_cnt = 0;
            start = 1'b1;
            step(2);
            checks++;
            if (sec_clear !== 1'b1 || game_over !== 1'b0) begin
                errors++;
                $display("FAIL b2b_arm round=%0d: clear=%b over=%b, required 1/0", r, sec_clear, game_over);
            end
            sec_in = 6'd0;
            enter_play("b2b");
            step(5);
            checks++;
            if (playing !== 1'b1 || time_left !== 6'(ROUND_LEN)) begin
                errors++;
                $display("FAIL b2b_start_held round=%0d: playing=%b time_left=%0d, required 1/%0d",
                         r, playing, time_left, ROUND_LEN);
            end
            start = 1'b0;
            sec = 0;
            paused = 1'b0;
            iter = 0;
            while (sec < ROUND_LEN && iter < 300) begin
                iter++;
                if ($urandom_range(0, 3) == 0) begin
                    paused = !paused;
                    pause_btn = paused;
                end else if (!paused) begin
                    sec++;
                    sec_in = 6'(sec);
                end
                step(int'($urandom_range(8, 14)));
                tl = exp_time_left(sec);
                checks++;
                if (sec < ROUND_LEN) begin
                    if (time_left !== 6'(tl) || playing !== !paused || sec_enable !== !paused
                        || game_over !== 1'b0 || warn !== exp_warn(tl, 1'b1)) begin
                        errors++;
                        $display("FAIL b2b_live sec=%0d paused=%b: tl=%0d play=%b en=%b over=%b warn=%b",
                                 sec, paused, time_left, playing, sec_enable, game_over, warn);
                    end
                end else begin
                    if (time_left !== 6'd0 || game_over !== 1'b1 || done_cnt != 1 || warn !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b_over round=%0d: tl=%0d over=%b done_pulses=%0d warn=%b",
                                 r, time_left, game_over, done_cnt, warn);
                    end
                end
            end
            checks++;
            if (sec < ROUND_LEN) begin
                errors++;
                $display("FAIL b2b_budget round=%0d: reached sec %0d, required %0d", r, sec, ROUND_LEN);
            end
            pause_btn = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_arm();
        test_countdown();
        test_glitch();
        test_pause();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
